// File: rtl/pf_ccc_dri_master.sv
// Fabric-side initiator for the PolarFire CCC/PLL dynamic reconfiguration interface:
// turns one host request into one DRI transaction and returns a response on ack or timeout.
module pf_ccc_dri_master #(
    parameter int unsigned TIMEOUT_CYCLES   = 255,
    parameter int unsigned ARST_HOLD_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [7:0]  REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [10:0] DRI_CTRL,
    output logic [32:0] DRI_WDATA,
    output logic        DRI_ARST_N,
    input  logic [32:0] DRI_RDATA,
    input  logic        DRI_INTERRUPT,
    output logic        IRQ_PENDING,
    input  logic        IRQ_CLEAR,
    output logic [7:0]  IRQ_COUNT
);

    typedef enum logic [2:0] {
        ST_ARST,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_RESP
    } state_t;

    localparam logic [7:0]  HOLD_LAST = 8'(ARST_HOLD_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  hold_cnt;
    logic [15:0] tmo_cnt;
    logic        irq_prev;
    logic        irq_edge;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign irq_edge = DRI_INTERRUPT & ~irq_prev;

    // DRI_CTRL doubles as the latched request: addr/WR/RD stay put through WAIT_ACK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_ARST;
            hold_cnt   <= '0;
            tmo_cnt    <= '0;
            REQ_READY  <= 1'b0;
            RSP_VALID  <= 1'b0;
            RSP_RDATA  <= '0;
            RSP_ERR    <= 1'b0;
            DRI_CTRL   <= '0;
            DRI_WDATA  <= '0;
            DRI_ARST_N <= 1'b0;
        end else begin
            case (state)
                ST_ARST: begin
                    if (hold_cnt == HOLD_LAST) begin
                        DRI_ARST_N <= 1'b1;
                        REQ_READY  <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        DRI_CTRL  <= {REQ_ADDR, REQ_WRITE, ~REQ_WRITE, 1'b1};
                        DRI_WDATA <= {1'b0, REQ_WDATA};
                        REQ_READY <= 1'b0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    DRI_CTRL[0] <= 1'b0;
                    tmo_cnt     <= '0;
                    state       <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // An ack on the terminal count still completes successfully.
                    if (DRI_RDATA[32]) begin
                        RSP_RDATA <= DRI_CTRL[2] ? 32'd0 : DRI_RDATA[31:0];
                        RSP_ERR   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        DRI_CTRL  <= '0;
                        state     <= ST_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        RSP_RDATA <= '0;
                        RSP_ERR   <= 1'b1;
                        RSP_VALID <= 1'b1;
                        DRI_CTRL  <= '0;
                        state     <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        REQ_READY <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_ARST;
            endcase
        end
    end

    // Interrupt tracking is independent of the transaction FSM; a new edge beats a clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_prev    <= 1'b0;
            IRQ_PENDING <= 1'b0;
            IRQ_COUNT   <= '0;
        end else begin
            irq_prev <= DRI_INTERRUPT;
            if (irq_edge) begin
                IRQ_PENDING <= 1'b1;
                IRQ_COUNT   <= sat_inc8(IRQ_COUNT);
            end else if (IRQ_CLEAR) begin
                IRQ_PENDING <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pf_ccc_dri_master.sv
// Randomized bench for pf_ccc_dri_master against a transaction-level reference model.
module tb_pf_ccc_dri_master;

    localparam int TMO  = 8;
    localparam int HOLD = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WRITE = 1'b0;
    logic [7:0]  REQ_ADDR = '0;
    logic [31:0] REQ_WDATA = '0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [10:0] DRI_CTRL;
    logic [32:0] DRI_WDATA;
    logic        DRI_ARST_N;
    logic [32:0] DRI_RDATA = '0;
    logic        DRI_INTERRUPT = 1'b0;
    logic        IRQ_PENDING;
    logic        IRQ_CLEAR = 1'b0;
    logic [7:0]  IRQ_COUNT;

    int n_vec = 0;
    int n_err = 0;

    pf_ccc_dri_master #(.TIMEOUT_CYCLES(TMO), .ARST_HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .DRI_CTRL(DRI_CTRL), .DRI_WDATA(DRI_WDATA), .DRI_ARST_N(DRI_ARST_N),
        .DRI_RDATA(DRI_RDATA), .DRI_INTERRUPT(DRI_INTERRUPT),
        .IRQ_PENDING(IRQ_PENDING), .IRQ_CLEAR(IRQ_CLEAR), .IRQ_COUNT(IRQ_COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Ack is a single-cycle pulse d cycles after the GO cycle (t counts from GO = 0).
    function automatic logic [32:0] ack_at(input int t, input int d, input logic [31:0] v);
        return (t == d) ? {1'b1, v} : {1'b0, $urandom()};
    endfunction

    task automatic arst_release;
        RESET = 1'b0;
        for (int k = 1; k <= HOLD; k++) begin
            step;
            check("arst_n", 64'(DRI_ARST_N), 64'(k == HOLD));
            check("arst_ready", 64'(REQ_READY), 64'(k == HOLD));
        end
    endtask

    task automatic wait_ready;
        for (int i = 0; i < 50 && !REQ_READY; i++) step;
        check("req_ready", 64'(REQ_READY), 64'd1);
    endtask

    task automatic do_txn(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input int d, input logic [31:0] ackd, input int hold);
        int t;
        bit ok;
        int lat;
        logic [31:0] erd;
        ok  = (d >= 1) && (d <= TMO);
        lat = ok ? d + 1 : TMO + 1;
        erd = (ok && !wr) ? ackd : 32'd0;
        wait_ready;
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        step;
        REQ_VALID = 1'b0;
        REQ_ADDR  = 8'($urandom());
        REQ_WDATA = $urandom();
        check("go_ctrl", 64'(DRI_CTRL), 64'({addr, wr, !wr, 1'b1}));
        check("go_wdata", 64'(DRI_WDATA), 64'({1'b0, wdata}));
        check("busy_ready", 64'(REQ_READY), 64'd0);
        t = 0;
        while (!RSP_VALID && t < 40) begin
            DRI_RDATA = ack_at(t, d, ackd);
            step;
            t++;
            if (!RSP_VALID) check("hold_ctrl", 64'(DRI_CTRL), 64'({addr, wr, !wr, 1'b0}));
        end
        check("rsp_lat", 64'(t), 64'(lat));
        check("rsp_err", 64'(RSP_ERR), 64'(!ok));
        check("rsp_rdata", 64'(RSP_RDATA), 64'(erd));
        check("rsp_ctrl", 64'(DRI_CTRL), 64'd0);
        for (int i = 0; i < hold; i++) begin
            DRI_RDATA = ack_at(t, d, ackd);
            step;
            t++;
            check("rsp_stable", 64'({RSP_VALID, RSP_ERR, RSP_RDATA}), 64'({1'b1, !ok, erd}));
        end
        RSP_READY = 1'b1;
        DRI_RDATA = ack_at(t, d, ackd);
        step;
        t++;
        RSP_READY = 1'b0;
        check("rsp_drop", 64'({RSP_VALID, REQ_READY}), 64'b01);
        while (t <= d) begin
            DRI_RDATA = ack_at(t, d, ackd);
            step;
            t++;
            check("late_ack", 64'({RSP_VALID, REQ_READY}), 64'b01);
        end
        DRI_RDATA = '0;
    endtask

    initial begin
        int m_prev, m_pend, m_cnt, edge_seen;
        logic intr, clr;

        // Reset state
        RESET = 1'b1;
        repeat (3) step;
        check("rst_ready", 64'(REQ_READY), 64'd0);
        check("rst_rsp", 64'({RSP_VALID, RSP_ERR, RSP_RDATA}), 64'd0);
        check("rst_ctrl", 64'(DRI_CTRL), 64'd0);
        check("rst_wdata", 64'(DRI_WDATA), 64'd0);
        check("rst_arst_n", 64'(DRI_ARST_N), 64'd0);
        check("rst_irq", 64'({IRQ_PENDING, IRQ_COUNT}), 64'd0);
        arst_release;

        // Directed transactions
        do_txn(1'b1, 8'h1C, 32'h0000_0019, 2, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 8'h04, 32'h1234_5678, 1, 32'hA5A5_5A5A, 5);
        do_txn(1'b0, 8'h10, 32'h0, 11, 32'h5555_AAAA, 0);
        do_txn(1'b0, 8'h20, 32'h0, TMO, 32'hCAFE_F00D, 1);
        do_txn(1'b1, 8'h21, 32'hFFFF_FFFF, 0, 32'h1111_2222, 2);
        do_txn(1'b0, 8'hFF, 32'h0, TMO + 1, 32'h3333_4444, 3);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom()), 8'($urandom()), $urandom(), int'($urandom_range(0, 12)),
                   $urandom(), int'($urandom_range(0, 5)));
        end

        // Interrupt tracking against a counting model
        m_prev = 0; m_pend = 0; m_cnt = 0;
        for (int i = 0; i < 720; i++) begin
            intr = 1'(i % 2);
            clr  = ($urandom_range(0, 3) == 0);
            DRI_INTERRUPT = intr;
            IRQ_CLEAR = clr;
            step;
            edge_seen = (intr && m_prev == 0) ? 1 : 0;
            if (edge_seen == 1) m_pend = 1;
            else if (clr) m_pend = 0;
            m_cnt = (m_cnt + edge_seen > 255) ? 255 : m_cnt + edge_seen;
            m_prev = int'(intr);
            check("irq_pending", 64'(IRQ_PENDING), 64'(m_pend));
            check("irq_count", 64'(IRQ_COUNT), 64'(m_cnt));
        end
        check("irq_saturated", 64'(IRQ_COUNT), 64'd255);
        DRI_INTERRUPT = 1'b0; IRQ_CLEAR = 1'b0;
        step;
        DRI_INTERRUPT = 1'b1; IRQ_CLEAR = 1'b1;
        step;
        check("irq_set_wins", 64'(IRQ_PENDING), 64'd1);
        IRQ_CLEAR = 1'b1;
        step;
        check("irq_lone_clear", 64'(IRQ_PENDING), 64'd0);
        DRI_INTERRUPT = 1'b0; IRQ_CLEAR = 1'b0;
        step;

        // Reset during WAIT_ACK aborts silently
        wait_ready;
        REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 8'h33; REQ_WDATA = 32'h0;
        step;
        REQ_VALID = 1'b0;
        step;
        step;
        check("mid_waiting", 64'({RSP_VALID, DRI_CTRL}), 64'({1'b0, 8'h33, 1'b0, 1'b1, 1'b0}));
        RESET = 1'b1;
        step;
        check("mid_ctrl", 64'(DRI_CTRL), 64'd0);
        check("mid_arst_n", 64'(DRI_ARST_N), 64'd0);
        check("mid_rsp", 64'({RSP_VALID, REQ_READY}), 64'd0);
        check("mid_irq_count", 64'(IRQ_COUNT), 64'd0);
        arst_release;
        do_txn(1'b0, 8'h08, 32'h0, 3, 32'h0BAD_CAFE, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
